sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO: storage array, read/write pointers, occupancy counter and status flags in one block.
- Parametrised successor to the team's dual-port FIFO memory. Adds internal pointer management, registered full/empty/almost flags, occupancy count, read-valid strobe and sticky overflow/underflow error flags.
- Used wherever producer and consumer share one clock domain.

---
 rtl/sync_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with pointers, occupancy count and status flags
//
// Purpose: storage array plus read/write pointer management for a FIFO whose
// producer and consumer share one clock. Full/empty come from the occupancy
// count, so the pointers carry no extra wrap bit.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst_n        - asynchronous active-low reset
//   winc, wdata  - write request and write data
//   rinc         - read request
//   clr_err      - synchronous clear of the sticky overflow/underflow flags
//   rdata        - registered read data, held when no read is accepted
//   rvalid       - one-cycle strobe, rdata updated by the previous edge
//   wfull        - FIFO full (registered)
//   rempty       - FIFO empty (registered)
//   almost_full  - count >= AFULL_LVL (registered)
//   almost_empty - count <= AEMPTY_LVL (registered)
//   count        - occupancy, 0..DEPTH
//   overflow     - sticky, write attempted while full
//   underflow    - sticky, read attempted while empty
module sync_fifo_ctrl #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_LVL);
  localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_LVL);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [ADDRSIZE-1:0] wptr_q, rptr_q;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid_q;
  logic                wfull_q, rempty_q, afull_q, aempty_q;
  logic                wfull_d, rempty_d, afull_d, aempty_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_en, rd_en;

  // Acceptance uses the registered flags, so a read on a full FIFO frees a
  // slot only for the following cycle, and a write on an empty FIFO cannot
  // be read back in the same cycle.
  assign wr_en = winc && !wfull_q;
  assign rd_en = rinc && !rempty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    // A fresh error event outranks a clear in the same cycle.
    overflow_d  = (overflow_q && !clr_err) || (winc && wfull_q);
    underflow_d = (underflow_q && !clr_err) || (rinc && rempty_q);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (rd_en) begin
        rdata_q <= mem_q[rptr_q];
        rptr_q  <= rptr_q + 1'b1;
      end
      rvalid_q    <= rd_en;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl against a queue model
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          rinc;
  logic          clr_err;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wfull;
  logic          rempty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo_ctrl #(
    .DATASIZE(DW), .ADDRSIZE(AW), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .clr_err(clr_err), .rdata(rdata), .rvalid(rvalid), .wfull(wfull),
    .rempty(rempty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of stored words plus the visible registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".wfull"}, 32'(wfull), 32'(n == DEPTH));
    chk({tag, ".rempty"}, 32'(rempty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AFULL));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEMPTY));
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
    chk({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, check 1ns after the edge.
  task automatic cyc(input string tag, input logic w, input logic [DW-1:0] d,
                     input logic r, input logic c);
    bit full, empty;
    winc = w; wdata = d; rinc = r; clr_err = c;
    @(posedge clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    m_rvalid = 1'b0;
    if (r && !empty) begin
      m_rdata  = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (w && !full) q.push_back(d);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (w && full)  m_ovf = 1'b1;
    if (r && empty) m_udf = 1'b1;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    model_reset();
    do_reset();

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_after_16", 32'(wfull), 32'd1);

    // Write into a full FIFO, then clear the error.
    cyc("ovf_write", 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc("clr_err", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(rdata), 32'(i));
    end
    cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("empty_after_drain", 32'(rempty), 32'd1);

    // Simultaneous write+read on empty.
    cyc("empty_rw", 1'b1, 8'h5C, 1'b1, 1'b0);
    chk("empty_rw_udf", 32'(underflow), 32'd1);
    chk("empty_rw_rvalid", 32'(rvalid), 32'd0);
    cyc("empty_rw_rd", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("empty_rw_data", 32'(rdata), 32'h5C);

    // Half-full streaming with simultaneous read/write; 40 cycles wraps pointers.
    for (int i = 0; i < 8; i++) cyc("half_fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc("half_rw", 1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("half_count", 32'(count), 32'd8);

    // Fill to full, then simultaneous read+write.
    for (int i = 0; i < 8; i++) cyc("top_fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc("full_rw", 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_ovf", 32'(overflow), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 19) == 0));

    // Async reset mid-burst with count=5 and rvalid=1.
    while (q.size() > 6) cyc("trim", 1'b0, 8'h00, 1'b1, 1'b0);
    while (q.size() < 6) cyc("grow", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst_wr", 1'b1, 8'h3D, 1'b0, 1'b0);
    cyc("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", 32'(rdata), 32'h3D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
